// File: rtl/dff_delay_line_if.sv
// rtl/dff_delay_line_if.sv - sample/control bundle for the programmable delay line
interface dff_delay_line_if #(
    parameter int WIDTH       = 3,
    parameter int MAX_LATENCY = 8
);
    localparam int CW = $clog2(MAX_LATENCY + 1);

    logic             en;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             lat_load;
    logic [CW-1:0]    lat_in;
    logic [CW-1:0]    latency;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    occupancy;

    modport master (
        output en, d, d_valid, lat_load, lat_in,
        input  latency, q, q_valid, occupancy
    );

    modport slave (
        input  en, d, d_valid, lat_load, lat_in,
        output latency, q, q_valid, occupancy
    );
endinterface

// File: rtl/dff_delay_line.sv
// rtl/dff_delay_line.sv - runtime-programmable delay line with per-stage valids
module dff_delay_line #(
    parameter int               WIDTH       = 3,
    parameter int               MAX_LATENCY = 8,
    parameter int               DEF_LATENCY = 1,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic           clk,
    input  logic           rst,
    dff_delay_line_if.slave bus
);
    localparam int CW = $clog2(MAX_LATENCY + 1);

    logic [WIDTH-1:0]       data_q  [MAX_LATENCY];
    logic [WIDTH-1:0]       data_d  [MAX_LATENCY];
    logic [MAX_LATENCY-1:0] valid_q;
    logic [MAX_LATENCY-1:0] valid_d;
    logic [CW-1:0]          latency_q;
    logic [CW-1:0]          latency_d;
    logic [CW-1:0]          occ_q;
    logic [CW-1:0]          occ_d;
    logic [WIDTH-1:0]       tap_data;
    logic                   tap_valid;
    logic [CW-1:0]          lat_clamped;

    // Output tap is a mux over registered stages, so it adds no cycle.
    always_comb begin
        tap_data  = data_q[0];
        tap_valid = valid_q[0];
        for (int i = 0; i < MAX_LATENCY; i++) begin
            if (latency_q == CW'(i + 1)) begin
                tap_data  = data_q[i];
                tap_valid = valid_q[i];
            end
        end
    end

    always_comb begin
        lat_clamped = bus.lat_in;
        if (bus.lat_in == '0) begin
            lat_clamped = CW'(1);
        end else if (bus.lat_in > CW'(MAX_LATENCY)) begin
            lat_clamped = CW'(MAX_LATENCY);
        end
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        latency_d = latency_q;
        occ_d     = occ_q;
        if (bus.en) begin
            data_d[0]  = bus.d;
            valid_d[0] = bus.d_valid;
            // A latency load drops every in-flight sample but keeps stage data.
            for (int i = 1; i < MAX_LATENCY; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = bus.lat_load ? 1'b0 : valid_q[i-1];
            end
            if (bus.lat_load) begin
                latency_d = lat_clamped;
                occ_d     = CW'(bus.d_valid);
            end else begin
                occ_d = occ_q + CW'(bus.d_valid) - CW'(tap_valid);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LATENCY; i++) begin
                data_q[i] <= RESET_VAL;
            end
            valid_q   <= '0;
            latency_q <= CW'(DEF_LATENCY);
            occ_q     <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            latency_q <= latency_d;
            occ_q     <= occ_d;
        end
    end

    assign bus.q         = tap_data;
    assign bus.q_valid   = tap_valid;
    assign bus.latency   = latency_q;
    assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_dff_delay_line.sv
// tb/tb_dff_delay_line.sv - table, directed and random checks of dff_delay_line
module tb_dff_delay_line;
    localparam int WIDTH = 3;
    localparam int MAXL  = 8;
    localparam int DEFL  = 1;
    localparam int RVAL  = 0;
    localparam int CW    = $clog2(MAXL + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dff_delay_line_if #(.WIDTH(WIDTH), .MAX_LATENCY(MAXL)) bus ();

    dff_delay_line #(
        .WIDTH(WIDTH), .MAX_LATENCY(MAXL), .DEF_LATENCY(DEFL), .RESET_VAL(WIDTH'(RVAL))
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: history of every sample accepted, newest first.
    int m_v[$];
    int m_d[$];
    int m_lat;

    typedef struct {
        int rst, en, dv, d, ll, li;
        int eq, eqv, eocc, elat;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int r, input int e, input int dv, input int dd,
                              input int ll, input int li);
        if (r != 0) begin
            m_v = {};
            m_d = {};
            for (int i = 0; i < MAXL; i++) begin
                m_v.push_back(0);
                m_d.push_back(RVAL);
            end
            m_lat = DEFL;
        end else if (e != 0) begin
            if (ll != 0) begin
                foreach (m_v[i]) m_v[i] = 0;
                m_lat = (li == 0) ? 1 : ((li > MAXL) ? MAXL : li);
            end
            m_v.push_front(dv);
            m_d.push_front(dd);
            void'(m_v.pop_back());
            void'(m_d.pop_back());
        end
    endtask

    function automatic int model_occ();
        int s = 0;
        for (int i = 0; i < m_lat; i++) s += m_v[i];
        return s;
    endfunction

    task automatic step(input int r, input int e, input int dv, input int dd,
                        input int ll, input int li);
        rst          = (r != 0);
        bus.en       = (e != 0);
        bus.d_valid  = (dv != 0);
        bus.d        = WIDTH'(dd);
        bus.lat_load = (ll != 0);
        bus.lat_in   = CW'(li);
        @(posedge clk);
        model_edge(r, e, dv, dd, ll, li);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " q"},         int'(bus.q),         m_d[m_lat-1]);
        chk({tag, " q_valid"},   int'(bus.q_valid),   m_v[m_lat-1]);
        chk({tag, " occupancy"}, int'(bus.occupancy), model_occ());
        chk({tag, " latency"},   int'(bus.latency),   m_lat);
    endtask

    function automatic vec_t mk(int r, int e, int dv, int dd, int ll, int li,
                                int eq, int eqv, int eocc, int elat);
        vec_t v;
        v.rst = r; v.en = e; v.dv = dv; v.d = dd; v.ll = ll; v.li = li;
        v.eq = eq; v.eqv = eqv; v.eocc = eocc; v.elat = elat;
        return v;
    endfunction

    int snap_q, snap_qv, snap_occ;

    initial begin
        bus.en = 1'b0; bus.d = '0; bus.d_valid = 1'b0; bus.lat_load = 1'b0; bus.lat_in = '0;

        // reset, DFF equivalence at L=1, then latency 5 ramp
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,1));
        tbl.push_back(mk(1,1,1,5,0,0, 0,0,0,1));
        tbl.push_back(mk(0,1,1,1,0,0, 1,1,1,1));
        tbl.push_back(mk(0,1,1,0,0,0, 0,1,1,1));
        tbl.push_back(mk(0,1,1,1,0,0, 1,1,1,1));
        tbl.push_back(mk(0,1,1,1,0,0, 1,1,1,1));
        tbl.push_back(mk(0,1,0,0,1,5, 1,0,0,5));
        tbl.push_back(mk(0,1,1,0,0,0, 0,0,1,5));
        tbl.push_back(mk(0,1,1,1,0,0, 1,0,2,5));
        tbl.push_back(mk(0,1,1,2,0,0, 1,0,3,5));
        tbl.push_back(mk(0,1,1,3,0,0, 0,0,4,5));
        tbl.push_back(mk(0,1,1,4,0,0, 0,1,5,5));
        tbl.push_back(mk(0,1,1,5,0,0, 1,1,5,5));
        tbl.push_back(mk(0,1,1,6,0,0, 2,1,5,5));
        tbl.push_back(mk(0,1,1,7,0,0, 3,1,5,5));

        // some activity before the first reset row
        step(1,1,0,0,0,0);
        step(0,1,1,3,1,4);
        step(0,1,1,6,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].dv, tbl[i].d, tbl[i].ll, tbl[i].li);
            chk($sformatf("tbl%0d q", i),         int'(bus.q),         tbl[i].eq);
            chk($sformatf("tbl%0d q_valid", i),   int'(bus.q_valid),   tbl[i].eqv);
            chk($sformatf("tbl%0d occupancy", i), int'(bus.occupancy), tbl[i].eocc);
            chk($sformatf("tbl%0d latency", i),   int'(bus.latency),   tbl[i].elat);
        end

        // stall with L=3 in flight; lat_load while stalled must be ignored
        step(0,1,1,1,1,3); check_model("stall_fill");
        step(0,1,1,2,0,0); check_model("stall_fill");
        step(0,1,1,3,0,0); check_model("stall_fill");
        snap_q = int'(bus.q); snap_qv = int'(bus.q_valid); snap_occ = int'(bus.occupancy);
        for (int i = 0; i < 4; i++) begin
            step(0,0,int'($urandom_range(1)),int'($urandom_range(7)),1,7);
            chk("stall q",       int'(bus.q),         snap_q);
            chk("stall q_valid", int'(bus.q_valid),   snap_qv);
            chk("stall occ",     int'(bus.occupancy), snap_occ);
            chk("stall latency", int'(bus.latency),   3);
        end
        step(0,1,1,4,0,0); chk("resume q", int'(bus.q), 2); check_model("resume");
        step(0,1,1,5,0,0); chk("resume q", int'(bus.q), 3); check_model("resume");

        // clamp low with flush, then clamp high
        step(0,1,1,1,1,5); step(0,1,1,2,0,0); step(0,1,1,3,0,0);
        chk("pre_clamp occ", int'(bus.occupancy), 3);
        step(0,1,1,6,1,0);
        chk("clamp0 latency", int'(bus.latency),   1);
        chk("clamp0 q",       int'(bus.q),         6);
        chk("clamp0 q_valid", int'(bus.q_valid),   1);
        chk("clamp0 occ",     int'(bus.occupancy), 1);
        step(0,1,0,2,0,0);
        chk("clamp0 next q_valid", int'(bus.q_valid),   0);
        chk("clamp0 next occ",     int'(bus.occupancy), 0);
        step(0,1,0,0,1,15);
        chk("clamp15 latency", int'(bus.latency), 8);

        // reset while occupancy is 4
        step(0,1,1,1,1,5); step(0,1,1,2,0,0); step(0,1,1,3,0,0); step(0,1,1,4,0,0);
        chk("pre_rst occ", int'(bus.occupancy), 4);
        step(1,1,1,5,0,0);
        chk("rst q_valid", int'(bus.q_valid),   0);
        chk("rst occ",     int'(bus.occupancy), 0);
        chk("rst latency", int'(bus.latency),   DEFL);
        chk("rst q",       int'(bus.q),         RVAL);
        for (int i = 0; i < 10; i++) begin
            step(0,1,0,int'($urandom_range(7)),0,0);
            chk("post_rst q_valid", int'(bus.q_valid), 0);
        end

        // randomized traffic against the history model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 2) ? 1 : 0,
                 ($urandom_range(99) < 80) ? 1 : 0,
                 int'($urandom_range(1)),
                 int'($urandom_range(7)),
                 ($urandom_range(99) < 6) ? 1 : 0,
                 int'($urandom_range(15)));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
